sync_fifo_buf: RTL and testbench

Single-clock FIFO buffer: parametrised successor to the team's write-only FIFO memory array. Adds read/write pointer management, full/empty/almost flags, an occupancy count and a registered read port. Depth is a true 2**ADDRSIZE. Used wherever a same-clock rate-decoupling buffer is needed, ahead of the dual-clock FIFO.

---
 rtl/sync_fifo_buf_pkg.sv | 24 ++
 rtl/sync_fifo_buf_if.sv | 30 +++
 rtl/sync_fifo_buf_dpram.sv | 40 ++++
 rtl/sync_fifo_buf.sv | 93 +++++++++
 tb/tb_sync_fifo_buf.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/sync_fifo_buf_pkg.sv
// Shared constants and helpers for the single-clock FIFO buffer.
// Optional error flags are enabled by defining SYNC_FIFO_ERR_EN.
package sync_fifo_pkg;

  // Default geometry and flag thresholds
  localparam int DATASIZE_DEF   = 8;
  localparam int ADDRSIZE_DEF   = 4;
  localparam int AFULL_LVL_DEF  = 14;
  localparam int AEMPTY_LVL_DEF = 2;

  // Pointers carry one extra wrap bit beyond the memory address
  localparam int PTR_EXTRA_BITS = 1;

  // Number of words held by a FIFO with the given address width
  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  // Width of the read/write pointers, including the wrap bit
  function automatic int ptr_width(input int addrsize);
    return addrsize + PTR_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/sync_fifo_buf_if.sv
// Handshake bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_buf_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                rinc;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                wfull;
  logic                rempty;
  logic                walmost_full;
  logic                ralmost_empty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output winc, wdata, rinc,
    input  rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_buf_dpram.sv
// Storage array for the FIFO: one write port, one registered read port.
// Only the read register is reset; the memory contents are not.
module fifo_dpram
  import sync_fifo_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                re,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);
  localparam int DEPTH = fifo_depth(ADDRSIZE);

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [DATASIZE-1:0] rdata_q;

  // Store the incoming word at the write address when a write is accepted
  always_ff @(posedge wclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Capture the addressed word on an accepted read; hold otherwise
  always_ff @(posedge wclk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO buffer: pointer management, occupancy flags/count and a
// registered read port around fifo_dpram. Flags decode from registered
// pointers only. Define SYNC_FIFO_ERR_EN to get sticky overflow/underflow.
module sync_fifo_buf
  import sync_fifo_pkg::*;
#(
  parameter int DATASIZE   = DATASIZE_DEF,
  parameter int ADDRSIZE   = ADDRSIZE_DEF,
  parameter int AFULL_LVL  = AFULL_LVL_DEF,
  parameter int AEMPTY_LVL = AEMPTY_LVL_DEF
) (
  input logic           wclk,
  input logic           wrst,
  sync_fifo_buf_if.slave bus
);
  localparam int PTRW = ptr_width(ADDRSIZE);
  localparam logic [PTRW-1:0] AFULL_C  = PTRW'(AFULL_LVL);
  localparam logic [PTRW-1:0] AEMPTY_C = PTRW'(AEMPTY_LVL);

  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [PTRW-1:0] count;
  logic            rvalid_q, rvalid_d;
  logic            full, empty, we, re;

  // Decode status from the registered pointers and work out accepted ops
  always_comb begin
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]) &&
               (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]);
    count    = wptr_q - rptr_q;
    we       = bus.winc && !full && !wrst;
    re       = bus.rinc && !empty && !wrst;
    wptr_d   = we ? wptr_q + PTRW'(1) : wptr_q;
    rptr_d   = re ? rptr_q + PTRW'(1) : rptr_q;
    rvalid_d = re;
  end

  // Advance pointers and the read-valid pulse; reset returns to empty
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  fifo_dpram #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .wclk  (wclk),
    .rst   (wrst),
    .we    (we),
    .waddr (wptr_q[ADDRSIZE-1:0]),
    .wdata (bus.wdata),
    .re    (re),
    .raddr (rptr_q[ADDRSIZE-1:0]),
    .rdata (bus.rdata)
  );

  assign bus.rvalid        = rvalid_q;
  assign bus.rempty        = empty;
  assign bus.wfull         = full;
  assign bus.count         = count;
  assign bus.walmost_full  = (count >= AFULL_C);
  assign bus.ralmost_empty = (count <= AEMPTY_C);

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  // Latch any write-while-full or read-while-empty until the next reset
  always_ff @(posedge wclk) begin
    if (wrst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.winc && full)  overflow_q  <= 1'b1;
      if (bus.rinc && empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_buf.sv
// Self-checking bench for sync_fifo_buf: directed steps plus a random run,
// compared every cycle against a queue-based model of the FIFO.
module tb_sync_fifo_buf;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 14;
  localparam int AEMPTY = 2;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic wclk = 1'b0;
  logic wrst = 1'b1;

  sync_fifo_buf_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

  sync_fifo_buf #(
    .DATASIZE   (DW),
    .ADDRSIZE   (AW),
    .AFULL_LVL  (AFULL),
    .AEMPTY_LVL (AEMPTY)
  ) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus.slave)
  );

  // Free-running clock
  always #5 wclk = ~wclk;

  int        checks = 0;
  int        errors = 0;
  string     phase  = "init";
  logic [7:0] q[$];
  logic [7:0] mRdata  = 8'h00;
  bit        mRvalid = 1'b0;
  bit        mOvf    = 1'b0;
  bit        mUnf    = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    int n;
    n = q.size();
    checkOutput("count",         32'(bus.count),       32'(n));
    checkOutput("rempty",        32'(bus.rempty),      32'(n == 0));
    checkOutput("wfull",         32'(bus.wfull),       32'(n == DEPTH));
    checkOutput("walmost_full",  32'(bus.walmost_full),  32'(n >= AFULL));
    checkOutput("ralmost_empty", 32'(bus.ralmost_empty), 32'(n <= AEMPTY));
    checkOutput("rvalid",        32'(bus.rvalid),      32'(mRvalid));
    checkOutput("rdata",         32'(bus.rdata),       32'(mRdata));
    checkOutput("overflow",      32'(bus.overflow),    32'(ERR_EN & mOvf));
    checkOutput("underflow",     32'(bus.underflow),   32'(ERR_EN & mUnf));
  endtask

  // One clock step: drive at the falling edge, update model at the rising edge, check just after
  task automatic applyStimulus(input bit w, input bit r, input logic [7:0] d, input bit rs);
    bit isFull, isEmpty;
    @(negedge wclk);
    bus.winc  = w;
    bus.rinc  = r;
    bus.wdata = d;
    wrst      = rs;
    @(posedge wclk);
    if (rs) begin
      q.delete();
      mRdata  = 8'h00;
      mRvalid = 1'b0;
      mOvf    = 1'b0;
      mUnf    = 1'b0;
    end else begin
      isFull  = (q.size() == DEPTH);
      isEmpty = (q.size() == 0);
      if (w && isFull)  mOvf = 1'b1;
      if (r && isEmpty) mUnf = 1'b1;
      if (r && !isEmpty) begin
        mRdata  = q.pop_front();
        mRvalid = 1'b1;
      end else begin
        mRvalid = 1'b0;
      end
      if (w && !isFull) q.push_back(d);
    end
    #1;
    checkAll();
  endtask

  initial begin
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.wdata = '0;

    phase = "reset";
    $display("[TB] phase %s", phase);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    phase = "fill";
    $display("[TB] phase %s", phase);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hAA, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    phase = "drain";
    $display("[TB] phase %s", phase);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);

    phase = "stream";
    $display("[TB] phase %s", phase);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0);

    phase = "simul_empty";
    $display("[TB] phase %s", phase);
    while (q.size() > 0) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0);

    phase = "simul_full";
    $display("[TB] phase %s", phase);
    while (q.size() < DEPTH) applyStimulus(1'b1, 1'b0, 8'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hC3, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    phase = "mid_reset";
    $display("[TB] phase %s", phase);
    while (q.size() > 9) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'(8'hE0 + i), 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);

    phase = "random";
    $display("[TB] phase %s", phase);
    for (int seg = 0; seg < 8; seg++) begin
      int wBias;
      wBias = (seg % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 50; i++) begin
        applyStimulus($urandom_range(0, 99) < wBias,
                      $urandom_range(0, 99) < (100 - wBias),
                      8'($urandom),
                      $urandom_range(0, 149) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
